// File: rtl/pixel_stream_bridge_pkg.sv
// pixel_stream_pkg: shared types for the camera-to-display pixel bridge.
// Decimation and state enums, per-entry FIFO tag, grid/decode helpers.
package pixel_stream_pkg;

    typedef enum logic [1:0] {
        DECIM_1 = 2'd0,
        DECIM_2 = 2'd1,
        DECIM_4 = 2'd2
    } decim_e;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        RESYNC   = 2'd2
    } state_e;

    // Metadata stored with every FIFO entry; the top pairs it with
    // the pixel data as {sof, data}. dm rides along so the output
    // side advances coordinates with the frame's own decimation.
    typedef struct packed {
        logic   sof;
        decim_e dm;
    } entry_tag_t;

    // Reserved mode 3 behaves as 1:1.
    function automatic decim_e decim_decode(input logic [1:0] mode);
        decim_e r;
        case (mode)
            2'd1:    r = DECIM_2;
            2'd2:    r = DECIM_4;
            default: r = DECIM_1;
        endcase
        return r;
    endfunction

    function automatic logic on_grid(
        input logic [15:0] v,
        input decim_e      dm
    );
        logic [15:0] mask;
        mask = (16'd1 << dm) - 16'd1;
        return (v & mask) == 16'd0;
    endfunction

endpackage

// File: rtl/pixel_stream_bridge_if.sv
// Display-side valid/ready pixel stream with x/y/sof tags.
// master: bridge drives out_*, samples out_ready. slave: display side.
interface pixel_stream_bridge_if #(
    parameter int PIX_W = 16
) ();

    logic             out_valid;
    logic             out_ready;
    logic [PIX_W-1:0] out_data;
    logic [15:0]      out_x;
    logic [15:0]      out_y;
    logic             out_sof;

    modport master (
        output out_valid,
        output out_data,
        output out_x,
        output out_y,
        output out_sof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_x,
        input  out_y,
        input  out_sof,
        output out_ready
    );

endinterface

// File: rtl/pixel_stream_bridge_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, head valid whenever !empty.
// Ports: push/push_data, pop, head, full, empty. Push+pop when full is allowed.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit separates full from empty.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot being written.
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, do_push};
        rd_d = rd_q + {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/pixel_stream_bridge.sv
// pixel_stream_bridge: camera pixels -> optional 2:1/4:1 decimation -> FIFO
// -> valid/ready display stream tagged with x/y/sof; drops resync to next frame.
// Ports: clk, reset (async, high), frame_start, pix_valid, pix_data, decim_mode,
// disp (pixel_stream_bridge_if.master), overflow, drop_count.
// Option: PIXEL_STREAM_BRIDGE_BYTESWAP_EN swaps the bytes of out_data (PIX_W=16).
module pixel_stream_bridge
    import pixel_stream_pkg::*;
#(
    parameter int PIX_W = 16,
    parameter int SRC_W = 640,
    parameter int SRC_H = 480,
    parameter int DEPTH = 64,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 pix_valid,
    input  logic [PIX_W-1:0]     pix_data,
    input  logic [1:0]           decim_mode,
    pixel_stream_bridge_if.master disp,
    output logic                 overflow,
    output logic [CNT_W-1:0]     drop_count
);

    typedef struct packed {
        entry_tag_t       tag;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

    localparam int          EW        = $bits(fifo_entry_t);
    localparam logic [15:0] IN_X_LAST = 16'(SRC_W - 1);
    localparam logic [15:0] IN_Y_END  = 16'(SRC_H);

    state_e           state_q, state_d;
    logic [15:0]      in_x_q, in_x_d;
    logic [15:0]      in_y_q, in_y_d;
    decim_e           dm_q, dm_d;
    logic             sof_pend_q, sof_pend_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [15:0]      last_x_q, last_x_d;
    logic [15:0]      last_y_q, last_y_d;

    fifo_entry_t      push_entry;
    fifo_entry_t      head_entry;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    logic [15:0]      cur_x, cur_y;
    decim_e           cur_dm;
    logic             cur_sof;
    logic             live;
    logic             keep;

    logic [15:0]      x_max, y_max;
    logic [15:0]      head_x, head_y;
    logic [PIX_W-1:0] data_view;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop = !fifo_empty && disp.out_ready;

    // Input side. frame_start is folded in first so a coincident
    // pixel is treated as (0,0) of the new frame.
    always_comb begin
        state_d    = state_q;
        in_x_d     = in_x_q;
        in_y_d     = in_y_q;
        dm_d       = dm_q;
        sof_pend_d = sof_pend_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        push       = 1'b0;
        keep       = 1'b0;

        cur_x   = in_x_q;
        cur_y   = in_y_q;
        cur_dm  = dm_q;
        cur_sof = sof_pend_q;
        live    = (state_q == ACTIVE);

        if (frame_start) begin
            cur_x      = '0;
            cur_y      = '0;
            cur_dm     = decim_decode(decim_mode);
            cur_sof    = 1'b1;
            live       = 1'b1;
            state_d    = ACTIVE;
            in_x_d     = '0;
            in_y_d     = '0;
            dm_d       = cur_dm;
            sof_pend_d = 1'b1;
        end

        // in_y parks at SRC_H after the last line; later pixels vanish.
        if (pix_valid && live && cur_y != IN_Y_END) begin
            if (cur_x == IN_X_LAST) begin
                in_x_d = '0;
                in_y_d = cur_y + 16'd1;
            end else begin
                in_x_d = cur_x + 16'd1;
                in_y_d = cur_y;
            end
            keep = on_grid(cur_x, cur_dm) && on_grid(cur_y, cur_dm);
            if (keep) begin
                if (fifo_full && !pop) begin
                    ovf_d   = 1'b1;
                    state_d = RESYNC;
                    if (drop_q != {CNT_W{1'b1}}) begin
                        drop_d = drop_q + CNT_W'(1);
                    end
                end else begin
                    push       = 1'b1;
                    sof_pend_d = 1'b0;
                end
            end
        end

        push_entry.tag.sof = cur_sof;
        push_entry.tag.dm  = cur_dm;
        push_entry.data    = pix_data;
    end

    // Output side: head coordinate is the last popped one advanced,
    // or the origin for a frame's first entry.
    always_comb begin
        x_max  = 16'((SRC_W >> head_entry.tag.dm) - 1);
        y_max  = 16'((SRC_H >> head_entry.tag.dm) - 1);
        head_x = '0;
        head_y = '0;
        if (!head_entry.tag.sof) begin
            if (last_x_q == x_max) begin
                head_x = '0;
                head_y = (last_y_q == y_max) ? last_y_q
                                             : last_y_q + 16'd1;
            end else begin
                head_x = last_x_q + 16'd1;
                head_y = last_y_q;
            end
        end
        last_x_d = pop ? head_x : last_x_q;
        last_y_d = pop ? head_y : last_y_q;
    end

`ifdef PIXEL_STREAM_BRIDGE_BYTESWAP_EN
    if (PIX_W != 16) begin : g_bad_pix_w
        $error("byte swap requires PIX_W = 16");
    end
    assign data_view = {head_entry.data[7:0], head_entry.data[15:8]};
`else
    assign data_view = head_entry.data;
`endif

    assign disp.out_valid = !fifo_empty;
    assign disp.out_data  = fifo_empty ? '0 : data_view;
    assign disp.out_x     = fifo_empty ? '0 : head_x;
    assign disp.out_y     = fifo_empty ? '0 : head_y;
    assign disp.out_sof   = !fifo_empty && head_entry.tag.sof;
    assign overflow       = ovf_q;
    assign drop_count     = drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= WAIT_SOF;
            in_x_q     <= '0;
            in_y_q     <= '0;
            dm_q       <= DECIM_1;
            sof_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
            last_x_q   <= '0;
            last_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_x_q     <= in_x_d;
            in_y_q     <= in_y_d;
            dm_q       <= dm_d;
            sof_pend_q <= sof_pend_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
        end
    end

endmodule

// File: tb/tb_pixel_stream_bridge.sv
// Testbench for pixel_stream_bridge: directed scenarios plus random traffic
// checked every cycle against a frame/queue model of the bridge.
module tb_pixel_stream_bridge;

    localparam int PIX_W = 16;
    localparam int SRC_W = 8;
    localparam int SRC_H = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              pix_valid = 1'b0;
    logic [PIX_W-1:0]  pix_data = '0;
    logic [1:0]        decim_mode = '0;
    logic              overflow;
    logic [CNT_W-1:0]  drop_count;

    pixel_stream_bridge_if #(.PIX_W(PIX_W)) disp ();

    pixel_stream_bridge #(
        .PIX_W (PIX_W),
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .decim_mode  (decim_mode),
        .disp        (disp),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          x;
        int          y;
        bit          sof;
    } pix_t;

    int   nvec = 0;
    int   nerr = 0;
    pix_t mq[$];
    pix_t got[$];
    int   m_mode = 0;
    int   m_k = 0;
    int   m_dm = 0;
    bit   m_sof = 0;
    bit   m_ovf = 0;
    int   m_drop = 0;

    function automatic logic [15:0] exp_d(input logic [15:0] v);
`ifdef PIXEL_STREAM_BRIDGE_BYTESWAP_EN
        return {v[7:0], v[15:8]};
`else
        return v;
`endif
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: source index within frame gives (x,y); kept pixels map to
    // (x>>dm, y>>dm); FIFO is a bounded queue.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_mode = 0;
            m_k    = 0;
            m_dm   = 0;
            m_sof  = 0;
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            bit   pop;
            bit   have;
            pix_t e;
            int   x;
            int   y;
            int   st;
            pop  = (mq.size() != 0) && disp.out_ready;
            have = 0;
            if (frame_start) begin
                m_mode = 1;
                m_k    = 0;
                m_dm   = (decim_mode == 2'd3) ? 0 : int'(decim_mode);
                m_sof  = 1;
            end
            if (pix_valid && m_mode == 1) begin
                x  = m_k % SRC_W;
                y  = m_k / SRC_W;
                st = 1 << m_dm;
                m_k++;
                if (y < SRC_H && x % st == 0 && y % st == 0) begin
                    if (mq.size() == DEPTH && !pop) begin
                        m_ovf  = 1;
                        m_mode = 2;
                        if (m_drop < (1 << CNT_W) - 1) m_drop++;
                    end else begin
                        e.d   = exp_d(pix_data);
                        e.x   = x / st;
                        e.y   = y / st;
                        e.sof = m_sof;
                        m_sof = 0;
                        have  = 1;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (have) mq.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", disp.out_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("out_data", disp.out_data, mq[0].d);
                chk("out_x", disp.out_x, mq[0].x);
                chk("out_y", disp.out_y, mq[0].y);
                chk("out_sof", disp.out_sof, mq[0].sof);
            end
            chk("overflow", overflow, m_ovf);
            chk("drop_count", drop_count, m_drop);
            if (disp.out_valid && disp.out_ready) begin
                pix_t p;
                p.d   = disp.out_data;
                p.x   = int'(disp.out_x);
                p.y   = int'(disp.out_y);
                p.sof = disp.out_sof;
                got.push_back(p);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [15:0] d, input bit fs, input logic [1:0] dm);
        pix_valid   = 1'b1;
        pix_data    = d;
        frame_start = fs;
        decim_mode  = dm;
        tick();
        pix_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic fstart(input logic [1:0] dm);
        frame_start = 1'b1;
        decim_mode  = dm;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    logic [15:0] s3_d [8] = '{16'd0, 16'd2, 16'd4, 16'd6,
                              16'd16, 16'd18, 16'd20, 16'd22};

    initial begin
        int s;
        int bias;
        disp.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_valid", disp.out_valid, 0);
        chk("rst_data", disp.out_data, 0);
        chk("rst_x", disp.out_x, 0);
        chk("rst_y", disp.out_y, 0);
        chk("rst_sof", disp.out_sof, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);

        // No frame_start: everything discarded.
        disp.out_ready = 1'b1;
        s = got.size();
        for (int i = 0; i < 32; i++) pix(16'(i), 1'b0, 2'd0);
        idle(3);
        chk("s1_none", got.size() - s, 0);
        chk("s1_valid", disp.out_valid, 0);
        chk("s1_drop", drop_count, 0);

        // Full-rate frame.
        fstart(2'd0);
        s = got.size();
        for (int i = 0; i < 32; i++) pix(16'(i), 1'b0, 2'd0);
        idle(4);
        chk("s2_cnt", got.size() - s, 32);
        if (got.size() >= s + 32) begin
            chk("s2_sof0", got[s].sof, 1);
            chk("s2_d0", got[s].d, exp_d(16'd0));
            chk("s2_d9", got[s+9].d, exp_d(16'd9));
            chk("s2_x9", got[s+9].x, 1);
            chk("s2_y9", got[s+9].y, 1);
            chk("s2_sof9", got[s+9].sof, 0);
            chk("s2_x31", got[s+31].x, 7);
            chk("s2_y31", got[s+31].y, 3);
        end

        // 2:1 decimation, then extra pixels past the last line.
        fstart(2'd1);
        s = got.size();
        for (int i = 0; i < 36; i++) pix(16'(i), 1'b0, 2'd1);
        idle(4);
        chk("s3_cnt", got.size() - s, 8);
        if (got.size() >= s + 8) begin
            for (int j = 0; j < 8; j++) begin
                chk("s3_d", got[s+j].d, exp_d(s3_d[j]));
                chk("s3_x", got[s+j].x, j % 4);
                chk("s3_y", got[s+j].y, j / 4);
            end
        end

        // Overflow and resync.
        disp.out_ready = 1'b0;
        fstart(2'd0);
        s = got.size();
        for (int i = 0; i < 6; i++) pix(16'(100 + i), 1'b0, 2'd0);
        chk("s4_ovf", overflow, 1);
        chk("s4_drop", drop_count, 1);
        chk("s4_valid", disp.out_valid, 1);
        for (int i = 0; i < 3; i++) pix(16'(106 + i), 1'b0, 2'd0);
        chk("s4_drop_hold", drop_count, 1);
        disp.out_ready = 1'b1;
        idle(6);
        chk("s4_cnt", got.size() - s, 4);
        if (got.size() >= s + 4) begin
            chk("s4_sof", got[s].sof, 1);
            chk("s4_d3", got[s+3].d, exp_d(16'd103));
            chk("s4_x3", got[s+3].x, 3);
        end
        s = got.size();
        fstart(2'd0);
        for (int i = 0; i < 3; i++) pix(16'(200 + i), 1'b0, 2'd0);
        idle(4);
        chk("s4_resume_cnt", got.size() - s, 3);
        if (got.size() >= s + 1) begin
            chk("s4_resume_sof", got[s].sof, 1);
            chk("s4_resume_d", got[s].d, exp_d(16'd200));
        end

        // Full FIFO with push and pop together.
        disp.out_ready = 1'b0;
        fstart(2'd0);
        s = got.size();
        for (int i = 0; i < 4; i++) pix(16'(300 + i), 1'b0, 2'd0);
        chk("s5_valid", disp.out_valid, 1);
        disp.out_ready = 1'b1;
        pix(16'd304, 1'b0, 2'd0);
        disp.out_ready = 1'b0;
        chk("s5_nodrop", drop_count, 1);
        pix(16'd305, 1'b0, 2'd0);
        chk("s5_still_full", drop_count, 2);
        disp.out_ready = 1'b1;
        idle(6);
        chk("s5_cnt", got.size() - s, 5);
        if (got.size() >= s + 5) begin
            chk("s5_d4", got[s+4].d, exp_d(16'd304));
            chk("s5_x4", got[s+4].x, 4);
        end

        // frame_start coincident with a mid-frame pixel.
        fstart(2'd0);
        s = got.size();
        for (int i = 0; i < 10; i++) pix(16'(400 + i), 1'b0, 2'd0);
        pix(16'hABCD, 1'b1, 2'd0);
        pix(16'h1111, 1'b0, 2'd0);
        pix(16'h2222, 1'b0, 2'd0);
        idle(4);
        chk("s6_cnt", got.size() - s, 13);
        if (got.size() >= s + 13) begin
            chk("s6_x9", got[s+9].x, 1);
            chk("s6_y9", got[s+9].y, 1);
            chk("s6_d", got[s+10].d, exp_d(16'hABCD));
            chk("s6_sof", got[s+10].sof, 1);
            chk("s6_x", got[s+10].x, 0);
            chk("s6_y", got[s+10].y, 0);
            chk("s6_x1", got[s+11].x, 1);
            chk("s6_sof1", got[s+11].sof, 0);
        end

        // Random traffic.
        bias = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) bias = $urandom_range(1, 5);
            disp.out_ready = ($urandom_range(0, 4) < bias);
            pix_valid      = ($urandom_range(0, 3) != 0);
            pix_data       = 16'($urandom);
            frame_start    = ($urandom_range(0, 59) == 0);
            decim_mode     = 2'($urandom_range(0, 3));
            tick();
        end
        pix_valid      = 1'b0;
        frame_start    = 1'b0;
        disp.out_ready = 1'b1;
        idle(10);
        chk("drain_empty", disp.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pixel_stream_bridge.md
Name: pixel_stream_bridge

Overview:
- Single-clock elastic buffer between the camera pixel assembler and the TFT display driver.
- Replaces the direct pixel wire and the planned RAM between them.
- Accepts strobed pixels with a frame-start pulse, optionally decimates 2:1 or 4:1 in both axes, and buffers pixels in a FIFO.
- Presents a valid/ready stream to the display side, tagged with x/y coordinates and start-of-frame; handles overflow with frame resync.

Parameters:
- PIX_W, 16, pixel width in bits.
- SRC_W, 640, source pixels per line.
- SRC_H, 480, source lines per frame.
- DEPTH, 64, FIFO entries (power of two, at least 2).
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of a frame (vsync edge, already in the clk domain).
- pix_valid  in  1  one-cycle strobe: pix_data holds a complete pixel.
- pix_data  in  PIX_W  pixel value.
- decim_mode  in  2  decimation: 0 = 1:1, 1 = 2:1, 2 = 4:1, 3 = reserved (treated as 0); sampled only on frame_start.
- out_ready  in  1  display side accepts the current pixel.
- out_valid  out  1  head pixel available.
- out_data  out  PIX_W  head pixel.
- out_x  out  16  column of the head pixel in decimated coordinates.
- out_y  out  16  row of the head pixel in decimated coordinates.
- out_sof  out  1  head pixel is the first pixel of a frame.
- overflow  out  1  sticky flag: a pixel was dropped because the FIFO was full.
- drop_count  out  CNT_W  saturating count of dropped pixels.

Behaviour:
- Reset: all outputs 0. FIFO empty; state WAIT_SOF; in_x = in_y = 0; active decimation 0.
- State WAIT_SOF: discard every pix_valid. frame_start moves to ACTIVE.
- State ACTIVE: each pix_valid advances in_x. On in_x = SRC_W-1, in_x wraps to 0 and in_y increments.
- Once in_y reaches SRC_H it saturates and further pixels are discarded silently; no overflow is flagged.
- Keep rule: a pixel is kept when in_x and in_y are both multiples of 2^dm (dm = active decimation).
- FIFO entry: a kept pixel is pushed as {sof, data}. sof = 1 for the first kept pixel after frame_start.
- Overflow: a kept pixel arriving while the FIFO is full is dropped. overflow is set, drop_count increments (saturating) and the state moves to RESYNC.
- State RESYNC: every pix_valid is discarded (not counted). The FIFO keeps draining. frame_start moves to ACTIVE.
- frame_start in any state: in_x = in_y = 0, dm loaded from decim_mode, next kept pixel tagged sof, state ACTIVE.
- frame_start and pix_valid in the same cycle: the pixel is pixel (0,0) of the new frame.
- Output: show-ahead FIFO. out_valid = !empty; out_data and out_sof come from the head entry.
- Pop occurs on out_valid && out_ready.
- Latency: a pixel pushed in cycle N is visible at the head in cycle N+1 if the FIFO was empty.
- Output coordinates, head entry with sof = 1: out_x = out_y = 0 for that pixel.
- Output coordinates, other entries: (out_x, out_y) is the previously popped coordinate advanced by one. out_x wraps at (SRC_W>>dm)-1 and out_y increments; out_y saturates at (SRC_H>>dm)-1.
- The output side uses the dm value latched with the frame's sof entry.
- Push and pop in the same cycle while full: the pop frees a slot, so the push succeeds and nothing is dropped. While empty: the push proceeds and there is no pop.
- out_ready high while out_valid is low has no effect.
- overflow and drop_count clear only on reset.

Optional Feature:
- Macro: PIXEL_STREAM_BRIDGE_BYTESWAP_EN.
- Defined: out_data presents the head pixel with its two bytes swapped (bits 7:0 on 15:8), matching the display's byte order for RGB565. This requires PIX_W = 16; elaboration fails otherwise.
- Undefined: out_data equals the stored pixel.

Decomposition:
- Shared package pixel_stream_pkg holds:
  - the decimation enum (DECIM_1, DECIM_2, DECIM_4);
  - the state enum (WAIT_SOF, ACTIVE, RESYNC);
  - the FIFO entry typedef {sof, data}.
- One sub-module, sync_fifo:
  - parametrised width and depth;
  - show-ahead head, full and empty flags;
  - simultaneous push and pop allowed when full.
- Coordinate counters and the state machine live in the top module.

Test Plan:
All scenarios use SRC_W = 8, SRC_H = 4, DEPTH = 4.
- Reset, then 32 pix_valid strobes with no frame_start -> out_valid stays 0; drop_count = 0.
- frame_start with decim_mode = 0, then 32 pixels with values 0..31, out_ready = 1 -> 32 outputs in order. Pixel 0 has out_sof = 1; pixel 9 appears at (1,1); the last pixel at (7,3).
- frame_start with decim_mode = 1, 32 pixels -> 8 outputs with values 0, 2, 4, 6, 16, 18, 20, 22; coordinates (0,0) through (3,1).
- out_ready = 0 with 6 kept pixels -> FIFO holds 4, overflow = 1, drop_count = 1. Further pixels are ignored until frame_start, then streaming resumes with out_sof = 1.
- FIFO full with simultaneous push and pop -> no drop, and the occupancy stays 4.
- frame_start coincident with pix_valid in mid-frame -> that pixel is output at (0,0) with out_sof = 1.
